// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory controller.
// Covers FSM states, access-size codes, byte-lane masks and load extension.
package dmem_pkg;

  typedef enum logic [2:0] {StClear, StIdle, StWait, StExec, StResp} state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Byte-enable mask for up to 8 lanes; a "word" covers the full data width (nbytes).
  function automatic logic [7:0] lane_mask(logic [1:0] size, logic [2:0] lane,
                                           int unsigned nbytes);
    logic [7:0] m;
    case (size)
      SZ_BYTE: m = 8'd1 << lane;
      SZ_HALF: m = 8'd3 << lane;
      SZ_WORD: m = 8'((16'd1 << nbytes) - 16'd1);
      default: m = 8'd0;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] load_ext(logic [1:0] size, logic sgn, logic [2:0] lane,
                                           logic [63:0] data);
    logic [63:0] sh;
    logic [63:0] r;
    sh = data >> {lane, 3'b000};
    case (size)
      SZ_BYTE: r = {{56{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: r = {{48{sgn & sh[15]}}, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response handshake bundle between the EXE/MEM register and the data memory.
interface data_mem_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy_clr;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy_clr
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy_clr
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered read.
// No reset so it maps onto block RAM.
module dmem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2048,
  localparam int unsigned NB    = DATA_W / 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic [NB-1:0]     we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_ctrl.sv
// Handshaked MEM-stage data memory: sized/extended accesses, wait states,
// range/alignment errors and a sequential clear after reset.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 2048,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_ctrl_if.slave bus
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned LaneW = $clog2(NB);
  localparam int unsigned IdxW  = $clog2(DEPTH);
  localparam logic [ADDR_W:0] Limit = (ADDR_W + 1)'(DEPTH * NB);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, sgn_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                cap;

  logic [ADDR_W-1:0]   off;
  logic [IdxW-1:0]     idx;
  logic [LaneW-1:0]    lane;
  logic [2:0]          lane3;
  logic                align_err, err;
  logic [7:0]          mask8;
  logic [63:0]         ext;
  logic [NB-1:0]       ram_we;
  logic [IdxW-1:0]     ram_addr;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata;

  always_comb begin
    off   = addr_q - ADDR_W'(BASE_ADDR);
    idx   = off[IdxW+LaneW-1:LaneW];
    lane  = off[LaneW-1:0];
    lane3 = 3'(lane);
    case (size_q)
      SZ_BYTE: align_err = 1'b0;
      SZ_HALF: align_err = lane[0];
      SZ_WORD: align_err = (lane != '0);
      default: align_err = 1'b1;
    endcase
    err   = ({1'b0, off} >= Limit) | align_err;
    mask8 = lane_mask(size_q, lane3, NB);
    ext   = load_ext(size_q, sgn_q, lane3, 64'(ram_rdata));
  end

  // The clear sequence owns the RAM port; otherwise the captured request addresses it,
  // so the read launched during WAIT is ready in EXEC.
  always_comb begin
    ram_we    = '0;
    ram_addr  = idx;
    ram_wdata = wdata_q << {lane, 3'b000};
    if (state_q == StClear) begin
      ram_addr  = clr_ptr_q;
      ram_wdata = '0;
      ram_we    = {NB{rst}};
    end else if (state_q == StExec && we_q && !err && rst) begin
      ram_we = NB'(mask8);
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cap       = 1'b0;
    unique case (state_q)
      StClear: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == IdxW'(DEPTH - 1)) state_d = StIdle;
      end
      StIdle: begin
        if (bus.req_valid) begin
          cap     = 1'b1;
          // One extra WAIT cycle covers the registered RAM read.
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StExec;
        else cnt_d = cnt_q - 4'd1;
      end
      StExec: begin
        err_d   = err;
        rdata_d = (err || we_q) ? '0 : DATA_W'(ext);
        state_d = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      sgn_q     <= 1'b0;
      size_q    <= SZ_BYTE;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      if (cap) begin
        we_q    <= bus.req_we;
        sgn_q   <= bus.req_signed;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.busy_clr  = (state_q == StClear);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed + randomized bench for data_mem_ctrl against a byte-array reference model.
module tb_data_mem_ctrl;
  localparam int unsigned WaitCycles = 1;
  localparam int unsigned Depth      = 2048;
  localparam int          Lat        = 2 + WaitCycles;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  data_mem_ctrl #(
    .DATA_W      (32),
    .ADDR_W      (32),
    .DEPTH       (Depth),
    .BASE_ADDR   (1024),
    .WAIT_CYCLES (WaitCycles)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem_m [0:8191];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8192; i++) mem_m[i] = 8'h00;
  endtask

  // Byte-addressed little-endian model computed straight from the access rules.
  task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] erd, output logic eerr);
    logic [31:0] off;
    logic [31:0] v;
    int nb;
    off  = a - 32'd1024;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    eerr = (sz == 2'd3) || (off >= 32'd8192) || ((off % nb) != 0);
    erd  = 32'h0;
    if (!eerr) begin
      if (we) begin
        for (int i = 0; i < nb; i++) mem_m[off + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(mem_m[off + i]) << (8 * i));
        if (sg && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        erd = v;
      end
    end
  endtask

  task automatic start_req(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
    int n;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (n >= 50) chk("req_ready_timeout", 64'(n), 64'(0));
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 60) begin
      @(posedge clk); @(negedge clk); lat++;
    end
  endtask

  task automatic run(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    logic [31:0] erd;
    logic eerr;
    int lat;
    model(we, sz, sg, a, wd, erd, eerr);
    start_req(we, sz, sg, a, wd);
    wait_rsp(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(Lat));
    chk({tag, "_rdata"}, 64'(bus.rsp_rdata), 64'(erd));
    chk({tag, "_err"}, 64'(bus.rsp_err), 64'(eerr));
    rd = bus.rsp_rdata;
    bus.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, r0, erd, a, wd;
    logic eerr, err0;
    logic [1:0] sz;
    int busy_n, rdy_bad, vld_bad, lat;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b0;
    model_clear();

    // Reset held for two edges, then the clear sequence
    @(posedge clk); @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
    chk("rst_busy_clr", 64'(bus.busy_clr), 64'(1));
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    busy_n = 0; rdy_bad = 0;
    while (bus.busy_clr && busy_n < 5000) begin
      if (bus.req_ready) rdy_bad++;
      bus.req_valid = 1'b1;  // requests during clear must be ignored
      busy_n++;
      @(posedge clk); @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("clear_cycles", 64'(busy_n), 64'(Depth));
    chk("clear_req_ready_low", 64'(rdy_bad), 64'(0));
    chk("idle_req_ready", 64'(bus.req_ready), 64'(1));

    run("ld_base", 1'b0, 2'd2, 1'b0, 32'd1024, 32'h0, rd);
    run("st_word", 1'b1, 2'd2, 1'b0, 32'd1028, 32'hDEADBEEF, rd);
    run("ld_word", 1'b0, 2'd2, 1'b0, 32'd1028, 32'h0, rd);
    chk("ld_word_const", 64'(rd), 64'h0000_0000_DEAD_BEEF);
    run("st_byte", 1'b1, 2'd0, 1'b0, 32'd1029, 32'h1234_5680, rd);
    run("ld_word2", 1'b0, 2'd2, 1'b0, 32'd1028, 32'h0, rd);
    chk("ld_word2_const", 64'(rd), 64'h0000_0000_DEAD_80EF);
    run("ld_sbyte", 1'b0, 2'd0, 1'b1, 32'd1029, 32'h0, rd);
    chk("ld_sbyte_const", 64'(rd), 64'h0000_0000_FFFF_FF80);
    run("ld_ubyte", 1'b0, 2'd0, 1'b0, 32'd1029, 32'h0, rd);
    chk("ld_ubyte_const", 64'(rd), 64'h0000_0000_0000_0080);
    run("ld_shalf", 1'b0, 2'd1, 1'b1, 32'd1030, 32'h0, rd);
    chk("ld_shalf_const", 64'(rd), 64'h0000_0000_FFFF_DEAD);

    // Error cases
    run("err_below", 1'b0, 2'd2, 1'b0, 32'd1020, 32'h0, rd);
    chk("err_below_flag", 64'(bus.rsp_err), 64'(1));
    run("err_st_above", 1'b1, 2'd2, 1'b0, 32'd1024 + 32'd8192, 32'hCAFEF00D, rd);
    chk("err_st_above_flag", 64'(bus.rsp_err), 64'(1));
    run("ld_after_err_st", 1'b0, 2'd2, 1'b0, 32'd1024, 32'h0, rd);
    chk("mem_unchanged", 64'(rd), 64'(0));
    run("err_misalign", 1'b0, 2'd2, 1'b0, 32'd1026, 32'h0, rd);
    chk("err_misalign_flag", 64'(bus.rsp_err), 64'(1));
    run("err_size3", 1'b0, 2'd3, 1'b0, 32'd1028, 32'h0, rd);
    chk("err_size3_flag", 64'(bus.rsp_err), 64'(1));
    run("st_top", 1'b1, 2'd2, 1'b0, 32'd1024 + 32'd8188, 32'hA5A5_0F0F, rd);
    run("ld_top", 1'b0, 2'd1, 1'b1, 32'd1024 + 32'd8190, 32'h0, rd);

    // Backpressure: response held for five cycles
    model(1'b0, 2'd2, 1'b0, 32'd1028, 32'h0, erd, eerr);
    start_req(1'b0, 2'd2, 1'b0, 32'd1028, 32'h0);
    wait_rsp(lat);
    chk("bp_lat", 64'(lat), 64'(Lat));
    r0 = bus.rsp_rdata;
    err0 = bus.rsp_err;
    chk("bp_rdata", 64'(r0), 64'(erd));
    rdy_bad = 0; vld_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_rdata !== r0 || bus.rsp_err !== err0) vld_bad++;
      if (bus.req_ready) rdy_bad++;
    end
    chk("bp_stable", 64'(vld_bad), 64'(0));
    chk("bp_req_ready_low", 64'(rdy_bad), 64'(0));
    bus.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp_valid_drop", 64'(bus.rsp_valid), 64'(0));
    chk("bp_back_idle", 64'(bus.req_ready), 64'(1));

    // Randomized accesses around the bottom of the window and the top boundary
    for (int i = 0; i < 40; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) a = 32'd1024 + 32'd8184 + 32'($urandom_range(0, 15));
      else a = 32'd1016 + 32'($urandom_range(0, 40));
      wd = $urandom;
      run("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd, rd);
    end

    // Reset during WAIT of a store drops it and restarts the clear
    run("pre_st", 1'b1, 2'd2, 1'b0, 32'd1036, 32'h0BAD_F00D, rd);
    start_req(1'b1, 2'd2, 1'b0, 32'd1032, 32'h1234_5678);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_valid", 64'(bus.rsp_valid), 64'(0));
    chk("mid_rst_busy", 64'(bus.busy_clr), 64'(1));
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    model_clear();
    busy_n = 0; vld_bad = 0;
    while (bus.busy_clr && busy_n < 5000) begin
      if (bus.rsp_valid) vld_bad++;
      busy_n++;
      @(posedge clk); @(negedge clk);
    end
    chk("mid_rst_clear_cycles", 64'(busy_n), 64'(Depth));
    chk("mid_rst_no_rsp", 64'(vld_bad), 64'(0));
    run("ld_after_rst", 1'b0, 2'd2, 1'b0, 32'd1032, 32'h0, rd);
    chk("ld_after_rst_zero", 64'(rd), 64'(0));
    run("ld_cleared", 1'b0, 2'd2, 1'b0, 32'd1036, 32'h0, rd);
    chk("ld_cleared_zero", 64'(rd), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
